// File: rtl/arm_multicycle_controller_pkg.sv
// Shared types and constants for the multicycle ARM controller.
package arm_multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  // Instruction classes (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // ALU operation selects
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Condition codes (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Evaluate a condition field against stored flags {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, ge;
    n  = flags[3];
    z  = flags[2];
    c  = flags[1];
    v  = flags[0];
    ge = (n == v);
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~(c & ~z);
      COND_GE: cond_check = ge;
      COND_LT: cond_check = ~ge;
      COND_GT: cond_check = ~z & ge;
      COND_LE: cond_check = z | ~ge;
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_multicycle_controller_cond_logic.sv
// Condition logic: NZCV flag storage, condition check and write gating.
module arm_multicycle_controller_cond_logic
  import arm_multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       next_pc,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q, cond_ex_delayed_d;
  logic       cond_ex;

  // Condition check on stored flags and next flag / delayed-condition values
  always_comb begin
    cond_ex           = cond_check(cond, flags_q);
    flags_d           = flags_q;
    cond_ex_delayed_d = cond_ex;
    if (flag_w[1] & cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  // Flag and delayed-condition registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q           <= 4'b0000;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  // Writes use the condition sampled a cycle earlier so an instruction's own
  // flag update cannot cancel its write-back; NextPC is never gated.
  always_comb begin
    pc_write  = (pcs & cond_ex_delayed_q) | next_pc;
    reg_write = reg_w & cond_ex_delayed_q;
    mem_write = mem_w & cond_ex_delayed_q;
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM controller: Moore main FSM, ALU/instruction decoders,
// and the condition-logic sub-block.
module arm_multicycle_controller
  import arm_multicycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:12] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  state_t     state_q, state_d;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       next_pc, reg_w, mem_w, branch, alu_op;
  logic [1:0] flag_w;
  logic       pcs;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and Moore control outputs
  always_comb begin
    state_d   = S_FETCH;
    next_pc   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        next_pc   = 1'b1;
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_w     = 1'b1;
        ResultSrc = 2'b01;
      end
      S_MEMWR: begin
        mem_w  = 1'b1;
        AdrSrc = 1'b1;
      end
      S_EXECUTER: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BRANCH: begin
        branch    = 1'b1;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end

  // ALU decoder: operation select and flag-write enables
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      // Only arithmetic ops touch C and V
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
    end
  end

  // Instruction decoder and PC-source logic
  always_comb begin
    RegSrc = {op == OP_MEM, op == OP_BR};
    ImmSrc = op;
    pcs    = ((rd == 4'hF) & reg_w) | branch;
  end

  arm_multicycle_controller_cond_logic u_cond_logic (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .next_pc   (next_pc),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_write  (PCWrite),
    .reg_write (RegWrite),
    .mem_write (MemWrite)
  );

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for the multicycle ARM controller.
module tb_arm_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:12] instr;
  logic [3:0]  alu_flags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  int checks;
  int failures;

  arm_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (instr),
    .ALUFlags   (alu_flags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare all outputs; RegSrc/ImmSrc expectations follow the current Op.
  task automatic chk(input string tag, input logic pcw, input logic mw, input logic rw,
                     input logic irw, input logic adr, input logic [1:0] asa,
                     input logic [1:0] asb, input logic [1:0] rs, input logic [1:0] alc);
    logic [16:0] obs, exp_v;
    logic [1:0]  op;
    op    = instr[27:26];
    obs   = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ALUControl, RegSrc, ImmSrc};
    exp_v = {pcw, mw, rw, irw, adr, asa, asb, rs, alc,
             op == 2'b01, op == 2'b10, op};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c_fetch(input string tag);
    chk(tag, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  task automatic c_decode(input string tag);
    chk(tag, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    alu_flags = 4'b0000;
    instr     = 20'hE5802;
    #2;
    c_fetch("reset_outputs");
    tick();
    c_fetch("reset_held");
    @(negedge clk);
    reset = 1'b1;

    // STR: FETCH -> DECODE -> MEMADR -> MEMWR -> FETCH
    tick(); c_decode("str_decode");
    tick(); chk("str_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(); chk("str_memwr",  0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); c_fetch("str_fetch2");

    // LDR: five cycles
    instr = 20'hE5902;
    tick(); c_decode("ldr_decode");
    tick(); chk("ldr_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(); chk("ldr_memrd",  0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); chk("ldr_memwb",  0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    tick(); c_fetch("ldr_fetch2");

    // ADD register
    instr = 20'hE0812;
    tick(); c_decode("addr_decode");
    tick(); chk("addr_executer", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); chk("addr_aluwb",    0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); c_fetch("addr_fetch2");

    // ADD immediate
    instr = 20'hE2812;
    tick(); c_decode("addi_decode");
    tick(); chk("addi_executei", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    tick(); chk("addi_aluwb",    0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();

    // ORR register and AND register decode
    instr = 20'hE1812;
    tick(); tick(); chk("orr_executer", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11);
    tick(); tick();
    instr = 20'hE0012;
    tick(); tick(); chk("and_executer", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10);
    tick(); tick();

    // SUBS with Z result sets the Z flag
    instr = 20'hE2512;
    tick(); c_decode("subs_decode");
    tick(); chk("subs_executei", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01);
    alu_flags = 4'b0100;
    tick(); alu_flags = 4'b0000;
    chk("subs_aluwb", 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); c_fetch("subs_fetch2");

    // BEQ taken (Z=1)
    instr = 20'h0A000;
    tick(); c_decode("beq_decode");
    tick(); chk("beq_branch", 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    tick(); c_fetch("beq_fetch2");

    // BNE not taken (Z=1)
    instr = 20'h1A000;
    tick(); c_decode("bne_decode");
    tick(); chk("bne_branch", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    tick(); c_fetch("bne_fetch2");

    // ADDNE with Z=1: write-back suppressed
    instr = 20'h10812;
    tick(); tick();
    tick(); chk("addne_aluwb", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();

    // ADD to PC: PCWrite in ALUWB
    instr = 20'hE081F;
    tick(); c_decode("addpc_decode");
    tick(); chk("addpc_executer", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); chk("addpc_aluwb",    1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); c_fetch("addpc_fetch2");

    // Undefined opcode: DECODE -> UNKNOWN -> FETCH, nothing asserted
    instr = 20'hEC000;
    tick(); c_decode("und_decode");
    tick(); chk("und_unknown", 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick(); c_fetch("und_fetch2");

    // Reset mid-instruction returns to FETCH immediately
    instr = 20'hE5902;
    tick(); tick();
    chk("mid_memadr", 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    c_fetch("mid_reset_fetch");
    @(negedge clk);
    reset = 1'b1;
    tick(); c_decode("mid_after_decode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
